// File: rtl/tff_bank_ctrl.sv
// tff_bank_ctrl: sequences an external bank of W T flip-flops as a
// programmable-modulus up/down counter. The bank updates as q ^ t, so every
// cycle the controller drives t_vec = q_vec ^ (desired next value).
module tff_bank_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         mode_down,
    input  logic         one_shot,
    input  logic [W-1:0] term,
    input  logic [W-1:0] q_vec,
    output logic [W-1:0] t_vec,
    output logic [1:0]   state,
    output logic         busy,
    output logic         tc,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t r_state;
    logic   r_mode_down;
    logic   r_one_shot;
    logic   r_busy;
    logic   r_done;

    logic [W-1:0] w_t_inc;
    logic [W-1:0] w_t_dec;
    logic [W-1:0] w_t_term;
    logic [W-1:0] w_t_vec;
    logic         w_term_hit;
    logic         w_count;

    // Binary increment: bit i toggles when every lower bit is 1.
    function automatic logic [W-1:0] inc_toggles(input logic [W-1:0] q);
        logic [W-1:0] t;
        logic         carry;
        carry = 1'b1;
        for (int i = 0; i < W; i++) begin
            t[i]  = carry;
            carry = carry & q[i];
        end
        return t;
    endfunction

    // Binary decrement: bit i toggles when every lower bit is 0.
    function automatic logic [W-1:0] dec_toggles(input logic [W-1:0] q);
        logic [W-1:0] t;
        logic         borrow;
        borrow = 1'b1;
        for (int i = 0; i < W; i++) begin
            t[i]   = borrow;
            borrow = borrow & ~q[i];
        end
        return t;
    endfunction

    assign w_t_inc = inc_toggles(q_vec);
    assign w_t_dec = dec_toggles(q_vec);

    // Values at or above term count as terminal in up mode, so an
    // out-of-range load wraps straight back to 0.
    assign w_term_hit = r_mode_down ? (q_vec == '0) : (q_vec >= term);

    // Terminal step: one-shot holds; continuous up wraps to 0, continuous
    // down jumps from 0 to term.
    assign w_t_term = r_one_shot  ? '0 :
                      r_mode_down ? (q_vec ^ term) : q_vec;

    // A count step happens only in RUN with no higher-priority control.
    assign w_count = (r_state == S_RUN) && !reset && !stop && !load && !pause;
    assign tc      = w_count && w_term_hit;

    // Toggle selection, priority reset > stop > load > pause > count.
    always_comb begin
        w_t_vec = '0;
        if (!reset && !stop) begin
            if (load && (r_state != S_DONE)) begin
                w_t_vec = q_vec ^ load_val;
            end else if (w_count) begin
                if (w_term_hit) begin
                    w_t_vec = w_t_term;
                end else if (r_mode_down) begin
                    w_t_vec = w_t_dec;
                end else begin
                    w_t_vec = w_t_inc;
                end
            end
        end
    end

    assign t_vec = w_t_vec;
    assign state = r_state;
    assign busy  = r_busy;
    assign done  = r_done;

    // Control FSM with registered busy/done; modes latched only on start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mode_down <= 1'b0;
            r_one_shot  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!stop && start) begin
                        r_state     <= S_RUN;
                        r_mode_down <= mode_down;
                        r_one_shot  <= one_shot;
                        r_busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (pause) begin
                        r_state <= S_HOLD;
                    end else if (!load && w_term_hit && r_one_shot) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!pause) begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
